dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's data-memory interface. The LSU is the initiator; this block accepts its load/store requests and returns read data.
- Holds a word-addressed SRAM array with a programmable access latency.
- Valid/ready handshake on both the request and response channels, so the core can stall on memory.
- Exposes a transaction counter for simulation statistics.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- LATENCY, 2, extra wait cycles between accept and array access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset. Low = reset asserted.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wmask  in  4  byte enables for a store; bit i enables byte lane i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  address fault.
- txn_count  out  32  number of completed response handshakes; wraps at 2^32.

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0.
  - Array contents are not reset.
  - On the first rising edge with rst high, req_ready becomes 1.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept edge = rising edge with req_valid & req_ready. On it, latch we/addr/wdata/wmask, drop req_ready, load cnt=LATENCY.
  - If LATENCY=0, perform the access on this same edge and go to RESP; otherwise go to WAIT.
- WAIT:
  - Each edge decrements cnt.
  - On the edge where cnt==1: perform the access, go to RESP.
  - Result: rsp_valid first rises on edge accept+LATENCY (accept+0 when LATENCY=0).
- Access rules:
  - Fault when addr[1:0]!=0 or addr outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS). A fault leaves the array unmodified and sets rsp_err=1, rsp_rdata=0.
  - Word index = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH_WORDS) bits.
  - Store: write only the byte lanes enabled by wmask; rsp_rdata=0. wmask=0 is a legal no-op store, with no error.
  - Load: rsp_rdata = full word (the LSU extracts sub-words).
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_valid & rsp_ready: clear rsp_valid/rsp_rdata/rsp_err, increment txn_count, go to IDLE, set req_ready=1.
  - req_ready=0 throughout WAIT and RESP, so at most one outstanding transaction.
  - Minimum spacing between accepts is LATENCY+2 cycles.
- Request inputs are ignored while req_ready=0, regardless of req_valid.
- Reset mid-transaction: the pending request is dropped. A store whose access edge has not occurred never reaches the array. No response is issued and txn_count is not incremented.
- rsp_ready asserted before rsp_valid has no effect.

Test Plan:
- LATENCY=2: store addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 4'hF, rsp_ready=1 -> rsp_valid rises on accept+2 with rsp_err=0, rsp_rdata=0; txn_count=1. Then load 0x8000_0010 -> rsp_rdata=0xDEAD_BEEF.
- Byte store to 0x8000_0010, wmask 4'b0100, wdata 0x0055_0000, then load -> 0xDE55_BEEF.
- Load 0x7FFF_FFFC, load 0x8000_1000 (DEPTH 1024), store 0x8000_0002 -> each gives rsp_err=1, rsp_rdata=0. A following load of 0x8000_0000 returns unchanged prior data.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready=0, a new req_valid is ignored. Release -> one handshake, txn_count+1.
- LATENCY=0 build: back-to-back loads with req_valid and rsp_ready held high -> an accept every 2 cycles, rsp_valid on the cycle after each accept.
- Assert rst low during WAIT of a store to 0x8000_0020 (previously 0x1234_5678) -> all outputs go to reset values immediately. After release, load returns 0x1234_5678 and txn_count restarts from 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's data-memory interface.
// Accepts one load/store at a time from the LSU, waits LATENCY cycles,
// accesses a word-addressed SRAM array, then holds the response until the
// initiator takes it.
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous reset, active low
//   req_valid  request present          req_ready  responder can accept
//   req_we     1 = store, 0 = load      req_addr   byte address
//   req_wdata  store data               req_wmask  byte-lane enables
//   rsp_valid  response available       rsp_ready  initiator takes response
//   rsp_rdata  load data (0 on store/fault)
//   rsp_err    address fault
//   txn_count  completed response handshakes, wraps
//
// state  | meaning
// IDLE   | ready for a request; req_ready=1 from the first edge after reset
// WAIT   | request latched, counting down the access latency
// RESP   | access done, response held until rsp_ready
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] txn_count
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             acc_fire;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wmask;
  logic [31:0]      acc_offset;
  logic             acc_fault;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      rd_word;

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  // With zero latency the access happens on the accept edge itself, so the
  // live request fields are used instead of the (not yet loaded) latches.
  assign acc_fire  = (accept && (LAT == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));
  assign acc_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_wmask = (state == S_IDLE) ? req_wmask : lat_wmask;

  // Addresses below the base wrap to large offsets and fail the span compare.
  assign acc_offset = acc_addr - ADDR_BASE;
  assign acc_fault  = (acc_addr[1:0] != 2'b00) || (acc_offset >= SPAN);
  assign acc_idx    = acc_offset[IDX_W+1:2];
  assign rd_word    = mem[acc_idx];

  always_ff @(posedge clk) begin
    if (acc_fire && acc_we && !acc_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_wmask <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      txn_count <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            cnt       <= LAT;
            state     <= S_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            txn_count <= txn_count + 32'd1;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Access edge overrides the WAIT/IDLE next-state chosen above.
      if (acc_fire) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= acc_fault;
        rsp_rdata <= (acc_fault || acc_we) ? 32'd0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 built with LATENCY=2, instance 1 with
// LATENCY=0. A transaction-level model predicts every output each cycle.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = '0, rsp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] txn_count [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .txn_count(txn_count[0])
  );

  dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .txn_count(txn_count[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int unsigned cyc = 0;
  bit          m_busy [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_ready[2] = '{0, 0};
  int unsigned m_acc  [2] = '{0, 0};
  logic [31:0] m_txn  [2] = '{0, 0};
  logic [31:0] m_rdata[2] = '{0, 0};
  bit          m_err  [2] = '{0, 0};
  bit          p_we   [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata[2];
  logic [3:0]  p_mask [2];
  logic [31:0] sb [longint];

  task automatic model_access(input int i);
    longint key;
    logic [31:0] w;
    bit fault;
    key   = (longint'(i) << 32) | longint'(p_addr[i]);
    fault = (p_addr[i] % 4 != 0) || (p_addr[i] < BASE) || (p_addr[i] >= BASE + 32'd4096);
    w     = sb.exists(key) ? sb[key] : 32'h0;
    if (fault) begin
      m_err[i] = 1'b1;
      m_rdata[i] = 32'h0;
    end else if (p_we[i]) begin
      for (int b = 0; b < 4; b++)
        if (p_mask[i][b]) w[8*b +: 8] = p_wdata[i][8*b +: 8];
      sb[key] = w;
      m_err[i] = 1'b0;
      m_rdata[i] = 32'h0;
    end else begin
      m_err[i] = 1'b0;
      m_rdata[i] = w;
    end
    m_done[i] = 1'b1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_done[i] = 0; m_ready[i] = 0;
        m_txn[i] = 0; m_rdata[i] = 0; m_err[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i] && m_done[i] && rsp_ready[i]) begin
          m_txn[i]   = m_txn[i] + 1;
          m_busy[i]  = 0; m_done[i] = 0; m_ready[i] = 1;
          m_rdata[i] = 0; m_err[i] = 0;
        end else if (!m_busy[i] && m_ready[i] && req_valid[i]) begin
          p_we[i] = req_we[i]; p_addr[i] = req_addr[i];
          p_wdata[i] = req_wdata[i]; p_mask[i] = req_wmask[i];
          m_busy[i] = 1; m_ready[i] = 0; m_acc[i] = cyc;
        end else if (!m_busy[i]) begin
          m_ready[i] = 1;
        end
        if (m_busy[i] && !m_done[i] && cyc == m_acc[i] + lat_of(i)) model_access(i);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d req_ready", i), req_ready[i], m_ready[i]);
      chk($sformatf("u%0d rsp_valid", i), rsp_valid[i], m_busy[i] && m_done[i]);
      chk($sformatf("u%0d rsp_rdata", i), rsp_rdata[i], (m_busy[i] && m_done[i]) ? m_rdata[i] : 32'h0);
      chk($sformatf("u%0d rsp_err", i), rsp_err[i], m_busy[i] && m_done[i] && m_err[i]);
      chk($sformatf("u%0d txn_count", i), txn_count[i], m_txn[i]);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_txn(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                        output logic [31:0] rd, output logic er);
    int k;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_wmask[i] = mask; rsp_ready[i] = (hold == 0);
    k = 0;
    while (!req_ready[i] && k < 50) begin @(negedge clk); k++; end
    chk("ready_wait", req_ready[i], 1'b1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    k = 0;
    while (!rsp_valid[i] && k < 50) begin @(negedge clk); k++; end
    chk($sformatf("u%0d latency", i), k, lat_of(i));
    rd = rsp_rdata[i];
    er = rsp_err[i];
    if (hold > 0) begin
      // A competing store presented while busy must be ignored.
      req_valid[i] = 1'b1; req_we[i] = 1'b1; req_addr[i] = BASE;
      req_wdata[i] = 32'h0; req_wmask[i] = 4'hF;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid[i], 1'b1);
        chk("hold_rdata", rsp_rdata[i], rd);
        chk("hold_ready", req_ready[i], 1'b0);
      end
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  logic [31:0] rd, t0;
  logic        er;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0;
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst req_ready", req_ready[i], 1'b0);
      chk("rst rsp_valid", rsp_valid[i], 1'b0);
      chk("rst txn_count", txn_count[i], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("first req_ready", req_ready[0], 1'b1);

    do_txn(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("st rdata", rd, 32'h0);
    chk("st err", er, 1'b0);
    chk("st txn", txn_count[0], 32'd1);
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
    chk("ld full", rd, 32'hDEAD_BEEF);
    do_txn(0, 1, 32'h8000_0010, 32'h0055_0000, 4'b0100, 0, rd, er);
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
    chk("ld byte", rd, 32'hDE55_BEEF);
    do_txn(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, rd, er);

    do_txn(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er);
    chk("below err", er, 1'b1);
    chk("below rdata", rd, 32'h0);
    do_txn(0, 0, 32'h8000_1000, 32'h0, 4'h0, 0, rd, er);
    chk("above err", er, 1'b1);
    do_txn(0, 1, 32'h8000_0002, 32'h1111_1111, 4'hF, 0, rd, er);
    chk("misalign err", er, 1'b1);
    do_txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er);
    chk("after fault", rd, 32'hCAFE_F00D);
    chk("after fault err", er, 1'b0);

    do_txn(0, 1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    chk("mask0 err", er, 1'b0);
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
    chk("mask0 noop", rd, 32'hDE55_BEEF);

    t0 = txn_count[0];
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er);
    chk("bp rdata", rd, 32'hDE55_BEEF);
    chk("bp txn", txn_count[0], t0 + 32'd1);
    do_txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er);
    chk("intruder ignored", rd, 32'hCAFE_F00D);

    // zero-latency instance: back-to-back loads
    do_txn(1, 1, BASE, 32'h1122_3344, 4'hF, 0, rd, er);
    chk("l0 st err", er, 1'b0);
    t0 = txn_count[1];
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = BASE; rsp_ready[1] = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("b2b valid", rsp_valid[1], (j % 2) == 1);
      if (j % 2 == 1) chk("b2b rdata", rsp_rdata[1], 32'h1122_3344);
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    chk("b2b txn", txn_count[1], t0 + 32'd4);

    // reset during WAIT of a store
    do_txn(0, 1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0, rd, er);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8000_0020;
    req_wdata[0] = 32'hAAAA_5555; req_wmask[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid rst req_ready", req_ready[0], 1'b0);
    chk("mid rst rsp_valid", rsp_valid[0], 1'b0);
    chk("mid rst rdata", rsp_rdata[0], 32'h0);
    chk("mid rst err", rsp_err[0], 1'b0);
    chk("mid rst txn0", txn_count[0], 32'h0);
    chk("mid rst txn1", txn_count[1], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel req_ready", req_ready[0], 1'b1);
    do_txn(0, 0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er);
    chk("dropped store", rd, 32'h1234_5678);
    chk("txn restart", txn_count[0], 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
